// File: rtl/clock_setter.sv
// clock_setter: time/date entry controller; seeds from live BCD counters, edits with calendar limits, commits via load strobe.
module clock_setter #(
   parameter int BLINK_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [3:0] cur_yr3,
   input  logic [3:0] cur_yr2,
   input  logic [3:0] cur_yr1,
   input  logic [3:0] cur_yr0,
   input  logic [3:0] cur_month1,
   input  logic [3:0] cur_month0,
   input  logic [3:0] cur_day1,
   input  logic [3:0] cur_day0,
   input  logic [3:0] cur_hr1,
   input  logic [3:0] cur_hr0,
   input  logic [3:0] cur_min1,
   input  logic [3:0] cur_min0,
   output logic [3:0] set_yr3,
   output logic [3:0] set_yr2,
   output logic [3:0] set_yr1,
   output logic [3:0] set_yr0,
   output logic [3:0] set_month1,
   output logic [3:0] set_month0,
   output logic [3:0] set_day1,
   output logic [3:0] set_day0,
   output logic [3:0] set_hr1,
   output logic [3:0] set_hr0,
   output logic [3:0] set_min1,
   output logic [3:0] set_min0,
   output logic [2:0] field,
   output logic       hold,
   output logic       load,
   output logic       sec_clr,
   output logic       blink
);
   localparam logic [2:0] IDLE = 3'd0, SEED = 3'd1, EDIT_YR = 3'd2, EDIT_MON = 3'd3,
                          EDIT_DAY = 3'd4, EDIT_HR = 3'd5, EDIT_MIN = 3'd6, COMMIT = 3'd7;
   logic [2:0]  state, state_n;
   logic [7:0]  yr, mon, day, hr, mn;
   logic [7:0]  yr_n, mon_n, day_b, day_n, hr_n, mn_n;
   logic [15:0] cnt;
   logic        edit, inc;
   // Months/years are kept as two-digit BCD bytes; BCD byte order matches numeric order
   function automatic logic [7:0] mdays(input logic [7:0] m, input logic [7:0] y);
      logic leap;
      leap = y[4] ? (y[3:0] == 4'd2 || y[3:0] == 4'd6) : (y[3:0] == 4'd0 || y[3:0] == 4'd4 || y[3:0] == 4'd8);
      return m == 8'h02 ? (leap ? 8'h29 : 8'h28) :
             (m == 8'h04 || m == 8'h06 || m == 8'h09 || m == 8'h11) ? 8'h30 : 8'h31;
   endfunction
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] hi, input logic [7:0] lo);
      return v >= hi ? lo : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
   endfunction
   assign edit = state >= EDIT_YR && state <= EDIT_MIN;
   assign inc  = edit && btn_inc && !btn_mode;
   always_comb begin
      state_n = state == IDLE ? (btn_mode ? SEED : IDLE) : state == SEED ? EDIT_YR :
                state == COMMIT ? IDLE : btn_mode ? state + 3'd1 : state;
      yr_n  = state == SEED ? ((cur_yr3 == 4'd2 && cur_yr2 == 4'd0) ? {cur_yr1, cur_yr0} : 8'h00) :
              inc && state == EDIT_YR ? bcd_inc(yr, 8'h99, 8'h00) : yr;
      mon_n = state == SEED ? {cur_month1, cur_month0} :
              inc && state == EDIT_MON ? bcd_inc(mon, 8'h12, 8'h01) : mon;
      day_b = state == SEED ? {cur_day1, cur_day0} :
              inc && state == EDIT_DAY ? bcd_inc(day, mdays(mon, yr), 8'h01) : day;
      // Day is re-limited against the new year/month in the same cycle they change
      day_n = day_b > mdays(mon_n, yr_n) ? mdays(mon_n, yr_n) : day_b;
      hr_n  = state == SEED ? {cur_hr1, cur_hr0} : inc && state == EDIT_HR ? bcd_inc(hr, 8'h23, 8'h00) : hr;
      mn_n  = state == SEED ? {cur_min1, cur_min0} : inc && state == EDIT_MIN ? bcd_inc(mn, 8'h59, 8'h00) : mn;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         field   <= 3'd0;
         hold    <= 1'b0;
         load    <= 1'b0;
         sec_clr <= 1'b0;
         blink   <= 1'b0;
         cnt     <= 16'd0;
         yr      <= 8'h00;
         mon     <= 8'h01;
         day     <= 8'h01;
         hr      <= 8'h00;
         mn      <= 8'h00;
      end else begin
         state   <= state_n;
         field   <= (state_n >= EDIT_YR && state_n <= EDIT_MIN) ? state_n - 3'd1 : 3'd0;
         hold    <= state_n != IDLE;
         load    <= state_n == COMMIT;
         sec_clr <= state_n == COMMIT;
         yr      <= yr_n;
         mon     <= mon_n;
         day     <= day_n;
         hr      <= hr_n;
         mn      <= mn_n;
         if (!edit || btn_mode || btn_inc) begin
            cnt   <= 16'd0;
            blink <= 1'b0;
         end else if (cnt == 16'(BLINK_DIV - 1)) begin
            cnt   <= 16'd0;
            blink <= ~blink;
         end else begin
            cnt <= cnt + 16'd1;
         end
      end
   end
   assign set_yr3 = 4'd2;
   assign set_yr2 = 4'd0;
   assign {set_yr1, set_yr0}       = yr;
   assign {set_month1, set_month0} = mon;
   assign {set_day1, set_day0}     = day;
   assign {set_hr1, set_hr0}       = hr;
   assign {set_min1, set_min0}     = mn;
endmodule

// File: tb/tb_clock_setter.sv
// tb_clock_setter: calendar-level reference model checked every cycle, plus directed literal checks and random stimulus.
module tb_clock_setter;
   localparam int DIV = 4;
   logic       clk = 0, rst = 1, btn_mode = 0, btn_inc = 0;
   logic [3:0] cur_yr3, cur_yr2, cur_yr1, cur_yr0, cur_month1, cur_month0, cur_day1, cur_day0;
   logic [3:0] cur_hr1, cur_hr0, cur_min1, cur_min0;
   logic [3:0] set_yr3, set_yr2, set_yr1, set_yr0, set_month1, set_month0, set_day1, set_day0;
   logic [3:0] set_hr1, set_hr0, set_min1, set_min0;
   logic [2:0] field;
   logic       hold, load, sec_clr, blink;
   int tests = 0, fails = 0;
   bit en = 0;
   int cy = 2023, cmo = 7, cd = 15, ch = 13, cmi = 45;
   int m_ph = 0, m_f = 0, m_y = 2000, m_mo = 1, m_d = 1, m_h = 0, m_mi = 0, m_q = 0, yv;

   clock_setter #(.BLINK_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .cur_yr3(cur_yr3), .cur_yr2(cur_yr2), .cur_yr1(cur_yr1), .cur_yr0(cur_yr0),
      .cur_month1(cur_month1), .cur_month0(cur_month0), .cur_day1(cur_day1), .cur_day0(cur_day0),
      .cur_hr1(cur_hr1), .cur_hr0(cur_hr0), .cur_min1(cur_min1), .cur_min0(cur_min0),
      .set_yr3(set_yr3), .set_yr2(set_yr2), .set_yr1(set_yr1), .set_yr0(set_yr0),
      .set_month1(set_month1), .set_month0(set_month0), .set_day1(set_day1), .set_day0(set_day0),
      .set_hr1(set_hr1), .set_hr0(set_hr0), .set_min1(set_min1), .set_min0(set_min0),
      .field(field), .hold(hold), .load(load), .sec_clr(sec_clr), .blink(blink)
   );

   always #5 clk = ~clk;

   assign cur_yr3 = 4'(cy / 1000);
   assign cur_yr2 = 4'((cy / 100) % 10);
   assign cur_yr1 = 4'((cy / 10) % 10);
   assign cur_yr0 = 4'(cy % 10);
   assign {cur_month1, cur_month0} = {4'(cmo / 10), 4'(cmo % 10)};
   assign {cur_day1, cur_day0}     = {4'(cd / 10), 4'(cd % 10)};
   assign {cur_hr1, cur_hr0}       = {4'(ch / 10), 4'(ch % 10)};
   assign {cur_min1, cur_min0}     = {4'(cmi / 10), 4'(cmi % 10)};

   function automatic int md(int m, int y);
      if (m == 2) return (y % 4 == 0) ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      return 31;
   endfunction
   function automatic int mn(int a, int b);
      return a < b ? a : b;
   endfunction
   function automatic logic [7:0] b2(int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // Model: phase 0 idle, 1 seed, 2 editing field m_f, 3 commit; m_q counts quiet edit cycles
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ph = 0; m_f = 0; m_y = 2000; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_q = 0;
      end else begin
         case (m_ph)
            0: if (btn_mode) m_ph = 1;
            1: begin
               yv = cy;
               m_y = (yv >= 2000 && yv <= 2099) ? yv : 2000;
               m_mo = cmo; m_d = mn(cd, md(cmo, m_y)); m_h = ch; m_mi = cmi;
               m_ph = 2; m_f = 1; m_q = 0;
            end
            2: if (btn_mode) begin
               m_q = 0;
               if (m_f == 5) begin m_ph = 3; m_f = 0; end else m_f++;
            end else if (btn_inc) begin
               m_q = 0;
               case (m_f)
                  1: begin m_y = m_y == 2099 ? 2000 : m_y + 1; m_d = mn(m_d, md(m_mo, m_y)); end
                  2: begin m_mo = m_mo == 12 ? 1 : m_mo + 1; m_d = mn(m_d, md(m_mo, m_y)); end
                  3: m_d = m_d >= md(m_mo, m_y) ? 1 : m_d + 1;
                  4: m_h = (m_h + 1) % 24;
                  default: m_mi = (m_mi + 1) % 60;
               endcase
            end else m_q++;
            default: m_ph = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      logic [54:0] dv, ev;
      if (en) begin
         dv = {set_yr3, set_yr2, set_yr1, set_yr0, set_month1, set_month0, set_day1, set_day0,
               set_hr1, set_hr0, set_min1, set_min0, field, hold, load, sec_clr, blink};
         ev = {4'(m_y / 1000), 4'((m_y / 100) % 10), b2(m_y % 100), b2(m_mo), b2(m_d), b2(m_h), b2(m_mi),
               3'(m_ph == 2 ? m_f : 0), m_ph != 0, m_ph == 3, m_ph == 3, m_ph == 2 && ((m_q / DIV) % 2 == 1)};
         tests++;
         if (dv !== ev) begin
            fails++;
            $display("FAIL cycle_check t=%0t dut=%h model=%h", $time, dv, ev);
         end
      end
   end

   function automatic int dut_date();
      return (set_yr3 * 1000 + set_yr2 * 100 + set_yr1 * 10 + set_yr0) * 10000 +
             (set_month1 * 10 + set_month0) * 100 + set_day1 * 10 + set_day0;
   endfunction
   function automatic int dut_time();
      return (set_hr1 * 10 + set_hr0) * 100 + set_min1 * 10 + set_min0;
   endfunction

   task automatic chk(input string n, input int a, input int e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s got=%0d expected=%0d", n, a, e);
      end
   endtask

   task automatic cyc(input logic m, input logic i);
      btn_mode = m;
      btn_inc  = i;
      @(negedge clk);
      #1;
      btn_mode = 0;
      btn_inc  = 0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      en = 1;
      #1;
      chk("rst_date", dut_date(), 20000101);
      chk("rst_time", dut_time(), 0);
      chk("rst_field", field, 0);
      chk("rst_hold", hold, 0);
      rst = 0;
      repeat (5) cyc(0, 1);
      chk("idle_inc_date", dut_date(), 20000101);
      chk("idle_inc_field", field, 0);
      cyc(1, 0);
      chk("seed_hold", hold, 1);
      chk("seed_field", field, 0);
      cyc(0, 0);
      chk("seed_date", dut_date(), 20230715);
      chk("seed_time", dut_time(), 1345);
      chk("field_1", field, 1);
      for (int i = 2; i <= 5; i++) begin
         cyc(1, 0);
         chk("field_seq", field, i);
      end
      cyc(1, 0);
      chk("commit_load", load, 1);
      chk("commit_sec_clr", sec_clr, 1);
      chk("commit_date", dut_date(), 20230715);
      chk("commit_time", dut_time(), 1345);
      cyc(0, 0);
      chk("post_load", load, 0);
      chk("post_hold", hold, 0);
      cy = 2099; cmo = 12; cd = 31; ch = 23; cmi = 59;
      cyc(1, 0); cyc(0, 0); cyc(0, 1);
      chk("yr_wrap", dut_date(), 20001231);
      cyc(1, 0); cyc(0, 1);
      chk("mon_wrap", dut_date(), 20000131);
      cyc(1, 0); cyc(0, 1);
      chk("day_wrap", dut_date(), 20000101);
      cyc(1, 0); cyc(0, 1);
      chk("hr_wrap", dut_time(), 59);
      cyc(1, 0); cyc(0, 1);
      chk("min_wrap", dut_time(), 0);
      cyc(1, 0); cyc(0, 0);
      cy = 2024; cmo = 1; cd = 31; ch = 10; cmi = 0;
      cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(0, 1);
      chk("leap_clamp", dut_date(), 20240229);
      repeat (4) cyc(1, 0);
      cyc(0, 0);
      cmo = 2; cd = 29;
      cyc(1, 0); cyc(0, 0);
      chk("seed_leap", dut_date(), 20240229);
      cyc(0, 1);
      chk("nonleap_clamp", dut_date(), 20250228);
      repeat (5) cyc(1, 0);
      cyc(0, 0);
      cy = 2099;
      cyc(1, 0); cyc(0, 0);
      chk("seed_day_clamp", dut_date(), 20990228);
      cyc(0, 1);
      chk("y2000", dut_date(), 20000228);
      cyc(1, 0); cyc(1, 0); cyc(0, 1);
      chk("y2000_feb29", dut_date(), 20000229);
      cyc(0, 1);
      chk("feb_wrap", dut_date(), 20000201);
      cyc(1, 0); cyc(1, 1);
      chk("prio_field", field, 5);
      chk("prio_hr", dut_time(), 1000);
      chk("prio_blink", blink, 0);
      repeat (3) cyc(0, 0);
      chk("blink_lo", blink, 0);
      cyc(0, 0);
      chk("blink_hi", blink, 1);
      cyc(0, 1);
      chk("blink_clr", blink, 0);
      chk("min_inc", dut_time(), 1001);
      cyc(1, 0); cyc(0, 0);
      cy = 1999; cmo = 7; cd = 15;
      cyc(1, 0); cyc(0, 0);
      chk("yr_force", dut_date(), 20000715);
      cyc(1, 0); cyc(1, 0);
      chk("mid_field", field, 3);
      rst = 1;
      cyc(0, 0);
      chk("mid_rst_field", field, 0);
      chk("mid_rst_hold", hold, 0);
      chk("mid_rst_load", load, 0);
      rst = 0;
      cyc(0, 0);
      chk("mid_rst_after_load", load, 0);
      for (int n = 0; n < 4000; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 19) == 0) begin
            cy = $urandom_range(1990, 2110); cmo = $urandom_range(1, 12); cd = $urandom_range(1, 31);
            ch = $urandom_range(0, 23); cmi = $urandom_range(0, 59);
         end
         cyc($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
      end
      rst = 0;
      cyc(0, 0);
      en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/clock_setter.md
# clock_setter

Time/date entry controller for the clock/calendar display design. It is the write side of the calendar counter chain: it seeds working registers from the live BCD counters, lets the user step through year, month, day, hour and minute with two pushbuttons, and enforces calendar limits (month length, leap years) as each value is edited. On commit it issues a single load strobe that writes the edited values back into the counters and clears seconds. A blink output lets the display flash the field being edited.

## Interface
Parameters:
- BLINK_DIV, 50000, clk cycles per blink half-period (0.5 s at the 100 kHz tick clock); counter width 16 bits.

Ports:
- clk  in  1  system clock (the 100 kHz tick clock that drives the counters)
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- btn_mode  in  1  debounced single-cycle pulse; enter edit / advance field / commit
- btn_inc  in  1  debounced single-cycle pulse; increment current field
- cur_yr3, cur_yr2, cur_yr1, cur_yr0  in  4 each  live year BCD digits
- cur_month1, cur_month0, cur_day1, cur_day0  in  4 each  live date BCD digits
- cur_hr1, cur_hr0, cur_min1, cur_min0  in  4 each  live 24 h time BCD digits
- set_yr3, set_yr2, set_yr1, set_yr0  out  4 each  working year digits
- set_month1, set_month0, set_day1, set_day0  out  4 each  working date digits
- set_hr1, set_hr0, set_min1, set_min0  out  4 each  working time digits
- field  out  3  0 idle, 1 year, 2 month, 3 day, 4 hour, 5 minute
- hold  out  1  freeze counters while high
- load  out  1  one-cycle strobe; counters load set_* values
- sec_clr  out  1  one-cycle strobe coincident with load; seconds go to 00
- blink  out  1  display blank phase for the active field

## Operation
- States: IDLE, SEED, EDIT_YR, EDIT_MON, EDIT_DAY, EDIT_HR, EDIT_MIN, COMMIT. All outputs are registered.
- IDLE: btn_mode -> SEED. btn_inc is ignored.
- SEED, 1 cycle: capture all cur_* into the working registers, then go to EDIT_YR. A seeded year outside 2000–2099 is forced to 2000. A seeded day above the month maximum is clamped to that maximum.
- EDIT_*: btn_mode advances YR->MON->DAY->HR->MIN->COMMIT. btn_inc increments the active field.
- If btn_mode and btn_inc are both high in the same cycle, btn_mode wins and the increment is dropped.
- Increment and wrap rules, all in BCD with no binary intermediate exposed:
  - year 2000..2099, 2099->2000; only set_yr1/set_yr0 change, yr3/yr2 stay 2/0
  - month 01..12, 12->01
  - day 01..max, max->01
  - hour 00..23, 23->00
  - minute 00..59, 59->00
- Month max: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; 29 for February in a leap year, 28 otherwise.
- Leap year: (10*yr1+yr0) mod 4 == 0. Equivalently, yr1 even with yr0 in {0,4,8}, or yr1 odd with yr0 in {2,6}.
- Clamp: any change to year or month re-checks day. If day exceeds the new maximum, day becomes that maximum in the same cycle as the year/month update.
- COMMIT, 1 cycle: load=1 and sec_clr=1, then go to IDLE.
- hold=1 in SEED, all EDIT_* states and COMMIT; 0 in IDLE.
- field follows the state: 0 in IDLE, SEED and COMMIT; 1–5 in the EDIT states.
- blink counter: cleared in SEED, runs only in EDIT_*. It toggles blink every BLINK_DIV cycles. It is also cleared and forces blink=0 on every btn_mode or btn_inc pulse, so the edited value is immediately visible. blink=0 outside EDIT_*.
- Reset mid-edit: return to IDLE immediately; load and sec_clr are never issued.

## Timing
- Reset values: state IDLE, field 0, hold 0, load 0, sec_clr 0, blink 0, set_yr=2000, set_month=01, set_day=01, set_hr=00, set_min=00, blink counter 0.
- btn_mode in IDLE at cycle t: SEED at t+1 (hold=1), EDIT_YR at t+2 with set_* holding the cur_* values sampled at t+1.
- btn_inc at cycle t: updated set_* visible at t+1.
- btn_mode in EDIT_MIN at cycle t: load=sec_clr=1 at t+1 only; IDLE and hold=0 at t+2.
- set_* hold their values in IDLE, so the counters can sample them any time load is high.

## Test plan
- Reset then idle: rst pulse -> set_* = 2000/01/01 00:00, field 0, hold 0; btn_inc x5 -> no change.
- Seed and commit: cur = 2023/07/15 13:45, btn_mode x6 -> field sequence 1,2,3,4,5; load=1 for exactly one cycle with set_* = 2023/07/15 13:45; hold falls the next cycle.
- Wraps: minute 59 +1 -> 00; hour 23 +1 -> 00; month 12 +1 -> 01; year 2099 +1 -> 2000; day 31 in month 01 +1 -> 01.
- Leap clamp: seed 2024/01/31; in EDIT_MON btn_inc -> month 02, day 29. Advance to year; btn_inc to 2025 -> day becomes 28. Year 2000 -> Feb max 29.
- Priority and blink: btn_mode and btn_inc together in EDIT_HR -> field 5, hour unchanged. With BLINK_DIV=4, blink toggles every 4 cycles and drops to 0 on each button pulse.
- Reset mid-edit: rst asserted in EDIT_DAY -> next cycle IDLE, hold 0; load never pulses.
